// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge detector: two line buffers, 3-stage pipeline, packed edge-bit output words.
// Define SOBEL_MAX_NORM_EN to use max(|Gx|,|Gy|) as magnitude instead of |Gx|+|Gy|.
//
// state    | meaning
// S_IDLE   | waiting for a startOfFrame pixel; other pixels are discarded
// S_ACTIVE | frame in progress, pixels are windowed and filtered
module sobel_stream_filter #(
    parameter int PIXEL_WIDTH  = 8,
    parameter int LINE_WIDTH   = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int PACK_WIDTH   = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [PIXEL_WIDTH+2:0] thresholdIn,
    input  logic                   thresholdWe,
    input  logic [PIXEL_WIDTH-1:0] pixelIn,
    input  logic                   pixelValid,
    input  logic                   startOfFrame,
    output logic                   pixelReady,
    output logic [PACK_WIDTH-1:0]  edgeOut,
    output logic                   edgeValid,
    input  logic                   edgeReady,
    output logic                   edgeLast,
    output logic                   errorFlag
);
    localparam int GW    = PIXEL_WIDTH + 3;
    localparam int COL_W = $clog2(LINE_WIDTH);
    localparam int ROW_W = $clog2(FRAME_HEIGHT);
    localparam int POS_W = (PACK_WIDTH > 1) ? $clog2(PACK_WIDTH) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(FRAME_HEIGHT - 1);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(PACK_WIDTH - 1);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;
    state_t r_state, w_state_nxt;

    logic [COL_W-1:0]      r_col, w_cur_col;
    logic [ROW_W-1:0]      r_row, w_cur_row;
    logic [POS_W-1:0]      r_pos, w_cur_pos;
    logic [GW-1:0]         r_threshold;
    logic                  r_error;
    logic                  w_advance, w_accept, w_proc, w_frame_end, w_sync_err;

    logic [PIXEL_WIDTH-1:0] r_line0 [LINE_WIDTH];
    logic [PIXEL_WIDTH-1:0] r_line1 [LINE_WIDTH];
    logic [PIXEL_WIDTH-1:0] r_win [3][3];

    logic                  r_s1_valid, r_s1_mask, r_s1_last;
    logic [POS_W-1:0]      r_s1_pos;
    logic [GW-1:0]         r_s1_thr;
    logic                  r_s2_valid, r_s2_bit, r_s2_last;
    logic [POS_W-1:0]      r_s2_pos;
    logic [PACK_WIDTH-1:0] r_pack, w_word;
    logic [PACK_WIDTH-1:0] r_edge_out;
    logic                  r_edge_valid, r_edge_last;

    logic signed [GW-1:0]  w_p [3][3];
    logic signed [GW-1:0]  w_gx, w_gy;
    logic [GW-1:0]         w_ax, w_ay, w_mag;
    logic                  w_edge;

    assign w_advance   = ~(r_edge_valid & ~edgeReady);
    assign pixelReady  = w_advance;
    assign w_accept    = pixelValid & w_advance;
    assign w_proc      = w_accept & (startOfFrame | (r_state == S_ACTIVE));
    assign w_cur_col   = startOfFrame ? '0 : r_col;
    assign w_cur_row   = startOfFrame ? '0 : r_row;
    assign w_cur_pos   = startOfFrame ? LAST_POS : r_pos;
    assign w_frame_end = w_proc & (w_cur_row == LAST_ROW) & (w_cur_col == LAST_COL);
    assign w_sync_err  = w_proc & startOfFrame & (r_state == S_ACTIVE) &
                         ((r_row != '0) | (r_col != '0));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_proc) w_state_nxt = S_ACTIVE;
            S_ACTIVE: if (w_frame_end) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // r_pos counts down through the bit positions of the current output word
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_col       <= '0;
            r_row       <= '0;
            r_pos       <= LAST_POS;
            r_threshold <= '0;
            r_error     <= 1'b0;
        end else begin
            if (thresholdWe) r_threshold <= thresholdIn;
            if (w_sync_err)  r_error <= 1'b1;
            if (w_proc) begin
                if (w_frame_end) begin
                    r_col <= '0;
                    r_row <= '0;
                end else if (w_cur_col == LAST_COL) begin
                    r_col <= '0;
                    r_row <= w_cur_row + ROW_W'(1);
                end else begin
                    r_col <= w_cur_col + COL_W'(1);
                    r_row <= w_cur_row;
                end
                r_pos <= (w_frame_end || w_cur_pos == '0) ? LAST_POS : w_cur_pos - POS_W'(1);
            end
        end
    end

    // Line buffers and window hold pure data and are never reset
    always_ff @(posedge clock) begin
        if (w_proc) begin
            r_line0[w_cur_col] <= r_line1[w_cur_col];
            r_line1[w_cur_col] <= pixelIn;
            for (int i = 0; i < 3; i++) begin
                r_win[i][0] <= r_win[i][1];
                r_win[i][1] <= r_win[i][2];
            end
            r_win[0][2] <= r_line0[w_cur_col];
            r_win[1][2] <= r_line1[w_cur_col];
            r_win[2][2] <= pixelIn;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w_p[i][j] = $signed({3'b000, r_win[i][j]});
        w_gx = (w_p[0][2] + (w_p[1][2] <<< 1) + w_p[2][2]) - (w_p[0][0] + (w_p[1][0] <<< 1) + w_p[2][0]);
        w_gy = (w_p[2][0] + (w_p[2][1] <<< 1) + w_p[2][2]) - (w_p[0][0] + (w_p[0][1] <<< 1) + w_p[0][2]);
        w_ax = w_gx[GW-1] ? $unsigned(-w_gx) : $unsigned(w_gx);
        w_ay = w_gy[GW-1] ? $unsigned(-w_gy) : $unsigned(w_gy);
`ifdef SOBEL_MAX_NORM_EN
        w_mag = (w_ax > w_ay) ? w_ax : w_ay;
`else
        w_mag = w_ax + w_ay;
`endif
        w_edge = ~r_s1_mask & (w_mag > r_s1_thr);
    end

    // Word base clears at the first bit position, which also drops a word cut short by a restart
    always_comb begin
        w_word = (r_s2_pos == LAST_POS) ? '0 : r_pack;
        w_word[r_s2_pos] = r_s2_bit;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s1_valid   <= 1'b0;
            r_s1_mask    <= 1'b1;
            r_s1_last    <= 1'b0;
            r_s1_pos     <= LAST_POS;
            r_s1_thr     <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_bit     <= 1'b0;
            r_s2_last    <= 1'b0;
            r_s2_pos     <= LAST_POS;
            r_pack       <= '0;
            r_edge_out   <= '0;
            r_edge_valid <= 1'b0;
            r_edge_last  <= 1'b0;
        end else if (w_advance) begin
            r_s1_valid <= w_proc;
            if (w_proc) begin
                r_s1_mask <= (w_cur_row < ROW_W'(2)) | (w_cur_col < COL_W'(2));
                r_s1_last <= w_frame_end;
                r_s1_pos  <= w_cur_pos;
                r_s1_thr  <= r_threshold;
            end
            r_s2_valid <= r_s1_valid;
            r_s2_bit   <= w_edge;
            r_s2_last  <= r_s1_last;
            r_s2_pos   <= r_s1_pos;
            if (r_s2_valid) r_pack <= w_word;
            r_edge_valid <= r_s2_valid & (r_s2_pos == '0);
            r_edge_last  <= r_s2_valid & (r_s2_pos == '0) & r_s2_last;
            if (r_s2_valid && r_s2_pos == '0) r_edge_out <= w_word;
        end
    end

    assign edgeOut   = r_edge_out;
    assign edgeValid = r_edge_valid;
    assign edgeLast  = r_edge_last;
    assign errorFlag = r_error;
endmodule

// File: tb/tb_sobel_stream_filter.sv
// Scoreboard bench for sobel_stream_filter: frame-level reference model feeds an expected-word queue,
// a monitor pops and compares each word the DUT hands over.
module tb_sobel_stream_filter;
    localparam int PW = 8, LW = 64, FH = 4, PK = 32;
    localparam int NPIX = LW * FH;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [PW+2:0] thresholdIn = '0;
    logic          thresholdWe = 1'b0;
    logic [PW-1:0] pixelIn = '0;
    logic          pixelValid = 1'b0;
    logic          startOfFrame = 1'b0;
    logic          pixelReady;
    logic [PK-1:0] edgeOut;
    logic          edgeValid;
    logic          edgeReady;
    logic          edgeLast;
    logic          errorFlag;

    sobel_stream_filter #(.PIXEL_WIDTH(PW), .LINE_WIDTH(LW), .FRAME_HEIGHT(FH), .PACK_WIDTH(PK)) dut (
        .clock(clock), .reset(reset), .thresholdIn(thresholdIn), .thresholdWe(thresholdWe),
        .pixelIn(pixelIn), .pixelValid(pixelValid), .startOfFrame(startOfFrame), .pixelReady(pixelReady),
        .edgeOut(edgeOut), .edgeValid(edgeValid), .edgeReady(edgeReady), .edgeLast(edgeLast),
        .errorFlag(errorFlag)
    );

    always #5 clock = ~clock;

    typedef struct {logic [PK-1:0] w; logic last;} exp_t;
    exp_t          exp_q[$];
    logic [PK-1:0] rx_w[$];
    logic          rx_l[$];
    int            rx_count = 0;
    int            checks = 0, errors = 0;

    int            img[FH][LW];
    int            rnd_img[FH][LW];
    bit            m_active = 0, m_err = 0;
    int            m_row = 0, m_col = 0, m_thr = 0;
    logic [PK-1:0] m_word = '0;
    bit            bp_en = 0;
    int            hold_cnt = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Reference: the edge bit is defined directly on the frame image held so far
    function automatic void model_accept(input int pix, input bit sof);
        int gx, gy, ax, ay, mag, wt;
        logic [PK-1:0] one;
        bit e;
        exp_t x;
        if (sof) begin
            if (m_active && (m_row != 0 || m_col != 0)) m_err = 1;
            m_active = 1; m_row = 0; m_col = 0; m_word = '0;
        end else if (!m_active) return;
        img[m_row][m_col] = pix;
        e = 0;
        if (m_row >= 2 && m_col >= 2) begin
            gx = 0; gy = 0;
            for (int k = 0; k < 3; k++) begin
                wt = (k == 1) ? 2 : 1;
                gx += wt * (img[m_row-2+k][m_col] - img[m_row-2+k][m_col-2]);
                gy += wt * (img[m_row][m_col-2+k] - img[m_row-2][m_col-2+k]);
            end
            ax = (gx < 0) ? -gx : gx;
            ay = (gy < 0) ? -gy : gy;
`ifdef SOBEL_MAX_NORM_EN
            mag = (ax > ay) ? ax : ay;
`else
            mag = ax + ay;
`endif
            e = (mag > m_thr);
        end
        one = '0;
        one[0] = e;
        m_word = m_word | (one << (PK - 1 - (m_col % PK)));
        if (m_col % PK == PK - 1) begin
            x.w = m_word;
            x.last = (m_row == FH - 1 && m_col == LW - 1);
            exp_q.push_back(x);
            m_word = '0;
        end
        if (m_col == LW - 1) begin
            m_col = 0;
            if (m_row == FH - 1) begin m_row = 0; m_active = 0; end
            else m_row++;
        end else m_col++;
    endfunction

    function automatic int pat_px(input int pat, input int r, input int c);
        case (pat)
            0: return 100;
            1: return (c < 32) ? 0 : 255;
            2: return (r == 2 && c == 10) ? 255 : 0;
            default: return rnd_img[r][c];
        endcase
    endfunction

    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset) begin
            if (edgeValid && !edgeReady) check("pixelReady_stall", {63'd0, pixelReady}, 64'd0);
            if (edgeValid && edgeReady) begin
                rx_w.push_back(edgeOut);
                rx_l.push_back(edgeLast);
                rx_count++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_word actual=%h required=none", edgeOut);
                end else begin
                    e = exp_q.pop_front();
                    check("edgeOut", {32'd0, edgeOut}, {32'd0, e.w});
                    check("edgeLast", {63'd0, edgeLast}, {63'd0, e.last});
                end
            end
        end
    end

    initial begin : ready_driver
        edgeReady = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (!bp_en) edgeReady = 1'b1;
            else if (edgeValid && hold_cnt < 10) begin edgeReady = 1'b0; hold_cnt++; end
            else if (edgeValid) begin edgeReady = 1'b1; hold_cnt = 0; end
            else edgeReady = 1'b0;
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic send_pixel(input int pix, input bit sof);
        bit acc;
        int guard;
        if ($urandom_range(3) == 0) begin
            pixelValid = 1'b0;
            @(posedge clock); #1;
        end
        pixelIn = PW'(pix);
        startOfFrame = sof;
        pixelValid = 1'b1;
        acc = 0;
        guard = 0;
        while (!acc) begin
            @(negedge clock);
            acc = pixelReady;
            @(posedge clock); #1;
            guard++;
            if (guard > 1000) begin
                $display("FAIL pixel_accept_timeout actual=%0d required<=1000", guard);
                $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
                $fatal(1, "pixel never accepted");
            end
        end
        pixelValid = 1'b0;
        startOfFrame = 1'b0;
        model_accept(pix, sof);
    endtask

    task automatic send_frame(input int pat, input int npix);
        for (int i = 0; i < npix; i++)
            send_pixel(pat_px(pat, i / LW, i % LW), i == 0);
    endtask

    task automatic set_thr(input int v);
        thresholdIn = (PW+3)'(v);
        thresholdWe = 1'b1;
        @(posedge clock); #1;
        thresholdWe = 1'b0;
        m_thr = v;
    endtask

    task automatic fill_rnd();
        for (int r = 0; r < FH; r++)
            for (int c = 0; c < LW; c++)
                rnd_img[r][c] = $urandom_range(255);
    endtask

    task automatic wait_drain(input string name);
        int g = 0;
        while (exp_q.size() != 0 && g < 3000) begin
            @(posedge clock); #1;
            g++;
        end
        repeat (4) @(posedge clock);
        #1;
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin : stimulus
        int mark;
        repeat (3) @(posedge clock);
        #1;
        check("rst_pixelReady", {63'd0, pixelReady}, 64'd1);
        check("rst_edgeValid", {63'd0, edgeValid}, 64'd0);
        check("rst_edgeLast", {63'd0, edgeLast}, 64'd0);
        check("rst_edgeOut", {32'd0, edgeOut}, 64'd0);
        check("rst_errorFlag", {63'd0, errorFlag}, 64'd0);
        reset = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 5; i++) send_pixel($urandom_range(255), 0);

        set_thr(0);
        mark = rx_count;
        send_frame(0, NPIX);
        wait_drain("flat_drain");
        check("flat_count", 64'(rx_count - mark), 64'd8);
        check("flat_last7", {63'd0, rx_l[mark+7]}, 64'd1);
        check("flat_last6", {63'd0, rx_l[mark+6]}, 64'd0);

        set_thr(500);
        mark = rx_count;
        send_frame(1, NPIX);
        wait_drain("step_drain");
        check("step_row2_w1", {32'd0, rx_w[mark+5]}, 64'hC000_0000);
        check("step_row2_w0", {32'd0, rx_w[mark+4]}, 64'h0);

        set_thr(300);
        mark = rx_count;
        send_frame(2, NPIX);
        wait_drain("dot_drain");
        check("dot_bit20", {63'd0, rx_w[mark+4][20]}, 64'd1);
`ifdef SOBEL_MAX_NORM_EN
        check("dot_bit21", {63'd0, rx_w[mark+4][21]}, 64'd0);
`else
        check("dot_bit21", {63'd0, rx_w[mark+4][21]}, 64'd1);
`endif

        set_thr(500);
        bp_en = 1;
        mark = rx_count;
        send_frame(1, NPIX);
        wait_drain("bp_drain");
        bp_en = 0;
        check("bp_count", 64'(rx_count - mark), 64'd8);
        check("bp_row2_w1", {32'd0, rx_w[mark+5]}, 64'hC000_0000);

        for (int f = 0; f < 3; f++) begin
            fill_rnd();
            set_thr($urandom_range(200, 1200));
            bp_en = (f == 1);
            send_frame(3, NPIX);
            wait_drain("rnd_drain");
        end
        bp_en = 0;
        check("no_error_yet", {63'd0, errorFlag}, 64'd0);

        fill_rnd();
        send_frame(3, LW + 5);
        mark = rx_count;
        fill_rnd();
        send_frame(3, NPIX);
        wait_drain("sync_drain");
        check("sync_count", 64'(rx_count - mark), 64'd8);
        check("sync_errorFlag", {63'd0, errorFlag}, {63'd0, m_err});
        send_frame(1, NPIX);
        wait_drain("post_sync_drain");
        check("sync_err_sticky", {63'd0, errorFlag}, 64'd1);

        fill_rnd();
        send_frame(3, 2 * LW + 7);
        reset = 1'b0;
        #1;
        check("midrst_edgeValid", {63'd0, edgeValid}, 64'd0);
        check("midrst_pixelReady", {63'd0, pixelReady}, 64'd1);
        check("midrst_errorFlag", {63'd0, errorFlag}, 64'd0);
        exp_q.delete();
        m_active = 0; m_err = 0; m_thr = 0; m_word = '0; m_row = 0; m_col = 0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        mark = rx_count;
        for (int i = 0; i < 20; i++) send_pixel($urandom_range(255), 0);
        repeat (10) @(posedge clock);
        #1;
        check("no_sof_no_output", 64'(rx_count - mark), 64'd0);
        set_thr(400);
        mark = rx_count;
        send_frame(3, NPIX);
        wait_drain("after_rst_drain");
        check("after_rst_count", 64'(rx_count - mark), 64'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
